// File: rtl/latch_ctrl_pkg.sv
// Shared types and defaults for the latch bank write sequencer.
// The CLEAR state is always declared; only LATCH_BANK_CLEAR_EN builds make it reachable.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam int DEF_NREQ     = 2;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_OPEN_CYC = 2;
  localparam int MAX_DEPTH    = 64;

  // Returns all zeros for an out-of-range address so no latch is ever opened for it.
  function automatic logic [MAX_DEPTH-1:0] onehot(input int addr, input int depth);
    logic [MAX_DEPTH-1:0] r;
    r = '0;
    if (addr >= 0 && addr < depth && addr < MAX_DEPTH) begin
      r = MAX_DEPTH'(1) << addr;
    end
    return r;
  endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Client request bus plus latch bank drive signals for latch_bank_ctrl.
// With LATCH_BANK_CLEAR_EN defined the bus also carries clr_req / clr_ack.
interface latch_bank_ctrl_if
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEPTH) + 1
);

  // Handshake: a requester raises req[i] with stable addr/data and holds it until it
  // sees the one-cycle ack[i] pulse; it drops req the cycle after. No ready signal.
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [DEPTH-1:0]      lat_en;
  logic [WIDTH-1:0]      lat_d;
  logic                  lat_rst;
`ifdef LATCH_BANK_CLEAR_EN
  logic                  clr_req;
  logic                  clr_ack;

  modport master (
    output req, req_addr, req_data, clr_req,
    input  ack, err, busy, lat_en, lat_d, lat_rst, clr_ack
  );
  modport slave (
    input  req, req_addr, req_data, clr_req,
    output ack, err, busy, lat_en, lat_d, lat_rst, clr_ack
  );
`else
  modport master (
    output req, req_addr, req_data,
    input  ack, err, busy, lat_en, lat_d, lat_rst
  );
  modport slave (
    input  req, req_addr, req_data,
    output ack, err, busy, lat_en, lat_d, lat_rst
  );
`endif

endinterface

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// Combinational round-robin picker: lowest requester index at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    logic [IW:0] sum;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      if (!gnt_valid && req[sum[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write sequencer for a bank of level-sensitive latches: setup -> open -> hold per write.
// Optional LATCH_BANK_CLEAR_EN adds a two-cycle bank clear driven by clr_req / clr_ack.
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OPEN_CYC = DEF_OPEN_CYC,
  parameter int AW       = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  latch_bank_ctrl_if.slave    bus,
  output state_t              dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(OPEN_CYC + 2);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic [DEPTH-1:0] lat_en_q, lat_en_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             lat_rst_q, lat_rst_d;
  logic             clr_ack_q, clr_ack_d;
  logic             clr_go;

  logic [IW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic [MAX_DEPTH-1:0] oh_full;
  logic                 addr_oor;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req       (bus.req),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

`ifdef LATCH_BANK_CLEAR_EN
  assign clr_go = bus.clr_req;
`else
  assign clr_go = 1'b0;
`endif

  assign addr_oor = (addr_q >= AW'(DEPTH));

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      lat_d_q   <= '0;
      lat_en_q  <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      lat_rst_q <= 1'b1;
      clr_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      lat_d_q   <= lat_d_d;
      lat_en_q  <= lat_en_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      lat_rst_q <= lat_rst_d;
      clr_ack_q <= clr_ack_d;
    end
  end

  // Next-state logic; cnt_q times both the OPEN window and the two CLEAR cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_go) begin
          state_d = CLEAR;
        end else if (gnt_valid) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
      OPEN: begin
        if (cnt_q == CW'(OPEN_CYC - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
`ifdef LATCH_BANK_CLEAR_EN
      CLEAR: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: values computed here appear one edge later, so they are keyed on the
  // transition being taken. lat_d only moves on entry to SETUP, never while lat_en is high.
  always_comb begin
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    lat_d_d   = lat_d_q;
    lat_en_d  = '0;
    ack_d     = '0;
    err_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    lat_rst_d = (state_d == CLEAR);
    clr_ack_d = 1'b0;
    oh_full   = onehot(int'(addr_q), DEPTH);
    case (state_q)
      IDLE: begin
        if (state_d == SETUP) begin
          gnt_d   = gnt_idx;
          addr_d  = bus.req_addr[gnt_idx*AW +: AW];
          lat_d_d = bus.req_data[gnt_idx*WIDTH +: WIDTH];
        end
      end
      SETUP: begin
        lat_en_d = oh_full[DEPTH-1:0];
      end
      OPEN: begin
        if (state_d == OPEN) begin
          lat_en_d = oh_full[DEPTH-1:0];
        end else begin
          ack_d = NREQ'(1) << gnt_q;
          err_d = addr_oor;
        end
      end
      HOLD: begin
        ptr_d = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
      end
      CLEAR: begin
        clr_ack_d = (state_d == CLEAR);
      end
      default: begin
        lat_en_d = '0;
      end
    endcase
  end

  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.lat_en  = lat_en_q;
  assign bus.lat_d   = lat_d_q;
  assign bus.lat_rst = lat_rst_q;
  assign dbg_state   = state_q;

`ifdef LATCH_BANK_CLEAR_EN
  assign bus.clr_ack = clr_ack_q;
`else
  logic unused_clr;
  assign unused_clr = clr_ack_q ^ clr_ack_d;
`endif

endmodule
